// File: rtl/vid_timing_gen.sv
// Video timing generator: pixel-rate strobe, raster counters, sync/blank decode
// and a two-stage palette fetch pipeline that keeps colour, blank and syncs aligned.
module vid_timing_gen #(
    parameter int CLK_DIV      = 14,
    parameter int H_ACTIVE     = 336,
    parameter int H_TOTAL      = 456,
    parameter int H_SYNC_START = 360,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_ACTIVE     = 240,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic        CLOCK_100,
    input  logic        reset,
    input  logic [9:0]  PF_INDEX,
    input  logic [15:0] PAL_DATA,
    output logic [8:0]  PF_HPOS,
    output logic [8:0]  PF_VPOS,
    output logic [9:0]  PAL_ADDR,
    output logic        pix_ce,
    output logic        MCKF,
    output logic [15:0] VIDOUT,
    output logic        VIDBLANK_b,
    output logic        HSYNC_b,
    output logic        VSYNC_b,
    output logic        FRAME_START
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] HS_BEGIN = 9'(H_SYNC_START);
    localparam logic [8:0] HS_END   = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEGIN = 9'(V_SYNC_START);
    localparam logic [8:0] VS_END   = 9'(V_SYNC_START + V_SYNC_LEN);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [8:0]       hcount;
    logic [8:0]       vcount;

    logic active;
    logic hs;
    logic vs;
    logic first;

    logic s1_active;
    logic s1_hs;
    logic s1_vs;
    logic s1_first;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    // NOTE: pix_ce and MCKF are registered from div_next, so they are clean flop
    // outputs yet still equal the decode of the div value currently held.
    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            div    <= '0;
            pix_ce <= 1'b0;
            MCKF   <= 1'b0;
        end else begin
            div    <= div_next;
            pix_ce <= (div_next == DIV_LAST);
            MCKF   <= (div_next >= DIV_HALF);
        end
    end

    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign active = (hcount < H_ACT) && (vcount < V_ACT);
    assign hs     = (hcount >= HS_BEGIN) && (hcount < HS_END);
    assign vs     = (vcount >= VS_BEGIN) && (vcount < VS_END);
    assign first  = (hcount == '0) && (vcount == '0);

    assign PF_HPOS = hcount;
    assign PF_VPOS = vcount;

    // Stage 1 launches the palette read; stage 2 captures its data one pixel later
    // together with the delayed decode so blank/sync match the colour exactly.
    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            PAL_ADDR    <= '0;
            s1_active   <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            VIDOUT      <= '0;
            VIDBLANK_b  <= 1'b0;
            HSYNC_b     <= 1'b1;
            VSYNC_b     <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            if (pix_ce) begin
                PAL_ADDR    <= PF_INDEX;
                s1_active   <= active;
                s1_hs       <= hs;
                s1_vs       <= vs;
                s1_first    <= first;
                VIDOUT      <= s1_active ? PAL_DATA : 16'h0000;
                VIDBLANK_b  <= s1_active;
                HSYNC_b     <= ~s1_hs;
                VSYNC_b     <= ~s1_vs;
                FRAME_START <= s1_first;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomized scoreboard bench for vid_timing_gen on a reduced raster: the driver
// pushes per-pixel expectations from a linear-pixel model, the monitor pops them.
module tb_vid_timing_gen;

    localparam int CLK_DIV   = 14;
    localparam int HA        = 12;
    localparam int HT        = 20;
    localparam int HSS       = 14;
    localparam int HSL       = 3;
    localparam int VA        = 8;
    localparam int VT        = 12;
    localparam int VSS       = 9;
    localparam int VSL       = 2;
    localparam int FRAME_CYC = CLK_DIV * HT * VT;

    typedef struct packed {
        logic [15:0] color;
        logic        blank_b;
        logic        hs_b;
        logic        vs_b;
        logic        first;
        logic [8:0]  hpos;
        logic [8:0]  vpos;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [9:0]  PF_INDEX;
    logic [15:0] PAL_DATA;
    logic [8:0]  PF_HPOS;
    logic [8:0]  PF_VPOS;
    logic [9:0]  PAL_ADDR;
    logic        pix_ce;
    logic        MCKF;
    logic [15:0] VIDOUT;
    logic        VIDBLANK_b;
    logic        HSYNC_b;
    logic        VSYNC_b;
    logic        FRAME_START;

    logic [15:0] pal_mem [1024];
    exp_t        q [$];
    int          total;
    int          bad;
    bit          mon_en;
    bit          aborted;

    vid_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
        .H_SYNC_LEN(HSL), .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS),
        .V_SYNC_LEN(VSL)
    ) dut (
        .CLOCK_100(clk),
        .reset(reset),
        .PF_INDEX(PF_INDEX),
        .PAL_DATA(PAL_DATA),
        .PF_HPOS(PF_HPOS),
        .PF_VPOS(PF_VPOS),
        .PAL_ADDR(PAL_ADDR),
        .pix_ce(pix_ce),
        .MCKF(MCKF),
        .VIDOUT(VIDOUT),
        .VIDBLANK_b(VIDBLANK_b),
        .HSYNC_b(HSYNC_b),
        .VSYNC_b(VSYNC_b),
        .FRAME_START(FRAME_START)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous palette RAM with one cycle of read latency.
    always @(posedge clk) PAL_DATA <= pal_mem[PAL_ADDR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs during pixel period j (j counted from reset release):
    // the counters show pixel j, the video outputs show pixel j-2.
    function automatic exp_t make_exp(int j, logic [9:0] idx);
        exp_t e;
        int   p, h, v;
        bit   act;
        e.hpos = 9'(j % HT);
        e.vpos = 9'((j / HT) % VT);
        if (j < 2) begin
            e.color = '0; e.blank_b = 1'b0; e.hs_b = 1'b1; e.vs_b = 1'b1; e.first = 1'b0;
        end else begin
            p   = j - 2;
            h   = p % HT;
            v   = (p / HT) % VT;
            act = (h < HA) && (v < VA);
            e.color   = act ? pal_mem[idx] : 16'h0000;
            e.blank_b = act;
            e.hs_b    = !(h >= HSS && h < HSS + HSL);
            e.vs_b    = !(v >= VSS && v < VSS + VSL);
            e.first   = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_vidout"}, VIDOUT, 0);
        check({tag, "_blank_b"}, VIDBLANK_b, 0);
        check({tag, "_hsync_b"}, HSYNC_b, 1);
        check({tag, "_vsync_b"}, VSYNC_b, 1);
        check({tag, "_frame_start"}, FRAME_START, 0);
        check({tag, "_mckf"}, MCKF, 0);
        check({tag, "_pix_ce"}, pix_ce, 0);
        check({tag, "_hpos"}, PF_HPOS, 0);
        check({tag, "_vpos"}, PF_VPOS, 0);
        check({tag, "_pal_addr"}, PAL_ADDR, 0);
    endtask

    // Called just after a reset-release edge; leaves the bench at the start of period n.
    task automatic run(input int n);
        logic [9:0] idx;
        bit         got;
        q.delete();
        q.push_back(make_exp(0, '0));
        q.push_back(make_exp(1, '0));
        mon_en = 1'b1;
        for (int k = 0; k < n && !aborted; k++) begin
            idx      = 10'($urandom);
            PF_INDEX = idx;
            q.push_back(make_exp(k + 2, idx));
            got = 1'b0;
            for (int c = 0; c < CLK_DIV + 2 && !got; c++) begin
                @(negedge clk);
                got = pix_ce;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL ce_timeout: no pix_ce within %0d cycles, want one every %0d",
                         CLK_DIV + 2, CLK_DIV);
                aborted = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: tracks the position inside each pixel period from reset release.
    initial begin
        int   phase;
        int   cyc;
        int   last_fs;
        bit   fs_valid;
        exp_t e;
        phase    = 0;
        cyc      = 0;
        last_fs  = 0;
        fs_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                phase    = 0;
                fs_valid = 1'b0;
            end else begin
                cyc++;
                check("pix_ce", pix_ce, phase == CLK_DIV - 1);
                check("mckf", MCKF, phase >= CLK_DIV / 2);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty at %0t: got no expectation, want one", $time);
                end else begin
                    e = q[0];
                    check("frame_start", FRAME_START, (phase == 0) ? e.first : 1'b0);
                    check("vidout", VIDOUT, e.color);
                    check("vidblank_b", VIDBLANK_b, e.blank_b);
                    check("hsync_b", HSYNC_b, e.hs_b);
                    check("vsync_b", VSYNC_b, e.vs_b);
                    if (phase == CLK_DIV - 1) begin
                        check("pf_hpos", PF_HPOS, e.hpos);
                        check("pf_vpos", PF_VPOS, e.vpos);
                        void'(q.pop_front());
                    end
                end
                if (FRAME_START) begin
                    if (fs_valid)
                        check("frame_period", cyc - last_fs, FRAME_CYC);
                    last_fs  = cyc;
                    fs_valid = 1'b1;
                end
                phase = (phase == CLK_DIV - 1) ? 0 : phase + 1;
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        mon_en   = 1'b0;
        aborted  = 1'b0;
        reset    = 1'b1;
        PF_INDEX = '0;
        for (int i = 0; i < 1024; i++) pal_mem[i] = 16'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("init");
        @(posedge clk);
        #1 reset = 1'b0;

        // Two full frames, then stop mid-frame at (7,5).
        run(2 * HT * VT + 5 * HT + 7);

        if (!aborted) begin
            check("mid_hpos", PF_HPOS, 7);
            check("mid_vpos", PF_VPOS, 5);
            mon_en = 1'b0;
            reset  = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            check_reset_values("midreset");
            run(HT * VT + 60);
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
